// File: rtl/cmd_uart_wrapper.sv
// -----------------------------------------------------------------------------
// cmd_uart_wrapper
//
// Purpose:
//   Byte-to-command bridge between a UART transceiver and the command
//   processor. Two received bytes (high first) are assembled into one 16-bit
//   command, handed over with a cmd_rdy / clr_cmd_rdy handshake. Single-byte
//   responses from the command processor are forwarded to the UART
//   transmitter.
//
// Optional feature (compile-time macro):
//   CMD_TIMEOUT_EN  - when defined, a partially received command (high byte
//                     only) is discarded after TIMEOUT_CYCLES clocks without
//                     the low byte, and timeout_err pulses. When undefined the
//                     receiver waits indefinitely and timeout_err is tied 0.
//
// Handshakes:
//   rx_rdy/clr_rx_rdy : rx_rdy is a level held by the receiver; clr_rx_rdy
//                       mirrors it combinationally, so every byte is consumed
//                       in the single cycle it is presented.
//   cmd_rdy/clr_cmd_rdy: cmd_rdy is set when a command completes and cleared
//                       by clr_cmd_rdy; a simultaneous completion wins.
//   send_resp/trmt/tx_done: a request is accepted only while not busy; trmt
//                       pulses one cycle later; tx_done ends the transfer and
//                       produces a one-cycle resp_sent.
//
// Ports:
//   clk          in   system clock, rising edge
//   RST          in   asynchronous active-high reset
//   rx_data[7:0] in   received byte, valid while rx_rdy=1
//   rx_rdy       in   received byte available (level)
//   clr_rx_rdy   out  combinational acknowledge of rx_data
//   cmd[15:0]    out  assembled command {high_byte, low_byte}
//   cmd_rdy      out  new command held on cmd
//   clr_cmd_rdy  in   consumer acknowledge of cmd
//   resp[7:0]    in   response byte to transmit
//   send_resp    in   one-cycle transmit request
//   tx_data[7:0] out  byte presented to the UART transmitter
//   trmt         out  one-cycle transmit start
//   tx_done      in   transmitter finished the byte
//   resp_busy    out  response in flight
//   resp_sent    out  one-cycle pulse, response has left the transmitter
//   timeout_err  out  one-cycle pulse, partial command discarded
// -----------------------------------------------------------------------------
module cmd_uart_wrapper #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    output logic        resp_busy,
    output logic        resp_sent,
    output logic        timeout_err
);

    typedef enum logic {
        S_HIGH = 1'b0,
        S_LOW  = 1'b1
    } rx_state_t;

    rx_state_t   r_state;
    logic [7:0]  r_high;
    logic [15:0] r_cmd;
    logic        r_cmd_rdy;
    logic        w_cmd_done;

    logic [7:0]  r_tx_data;
    logic        r_trmt;
    logic        r_busy;
    logic        r_sent;

    // A byte is consumed in the same cycle it is presented.
    assign clr_rx_rdy = rx_rdy & ~RST;

    // Low byte arriving completes the command; this also takes priority over
    // an expiring timeout in the same cycle.
    assign w_cmd_done = (r_state == S_LOW) && rx_rdy;

`ifdef CMD_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout_err;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state       <= S_HIGH;
            r_high        <= 8'h00;
            r_cmd         <= 16'h0000;
            r_cmd_rdy     <= 1'b0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                S_HIGH: begin
                    if (rx_rdy) begin
                        r_high  <= rx_data;
                        r_cnt   <= '0;
                        r_state <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (rx_rdy) begin
                        r_cmd   <= {r_high, rx_data};
                        r_state <= S_HIGH;
                    end else if (r_cnt == CNT_MAX) begin
                        // Second byte never came: drop the partial command.
                        r_high        <= 8'h00;
                        r_timeout_err <= 1'b1;
                        r_state       <= S_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_HIGH;
            endcase

            if (w_cmd_done) begin
                r_cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    // Timeout length only matters when the timeout is compiled in.
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES > 1);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state   <= S_HIGH;
            r_high    <= 8'h00;
            r_cmd     <= 16'h0000;
            r_cmd_rdy <= 1'b0;
        end else begin
            case (r_state)
                S_HIGH: begin
                    if (rx_rdy) begin
                        r_high  <= rx_data;
                        r_state <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (rx_rdy) begin
                        r_cmd   <= {r_high, rx_data};
                        r_state <= S_HIGH;
                    end
                end
                default: r_state <= S_HIGH;
            endcase

            if (w_cmd_done) begin
                r_cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    assign timeout_err = 1'b0;
`endif

    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmd_rdy;

    // Transmit path: independent of the receive FSM.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_tx_data <= 8'h00;
            r_trmt    <= 1'b0;
            r_busy    <= 1'b0;
            r_sent    <= 1'b0;
        end else begin
            r_trmt <= 1'b0;
            r_sent <= 1'b0;
            if (!r_busy) begin
                if (send_resp) begin
                    r_tx_data <= resp;
                    r_trmt    <= 1'b1;
                    r_busy    <= 1'b1;
                end
            end else if (tx_done) begin
                r_sent <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign tx_data   = r_tx_data;
    assign trmt      = r_trmt;
    assign resp_busy = r_busy;
    assign resp_sent = r_sent;

endmodule

// File: doc/cmd_uart_wrapper.md
# cmd_uart_wrapper

Knight-side byte-to-command bridge between the UART transceiver and the command processor. Assembles two received UART bytes (high first) into one 16-bit command with a `cmd_rdy`/`clr_cmd_rdy` handshake. Forwards single-byte responses (0xA5 positive ack, 0x5A move ack) from the command processor to the UART transmitter. It is the DUT-side consumer of every frame the bench's send-command path issues, and the producer of every `resp` byte the bench checks.

## Interface
- `TIMEOUT_CYCLES`, default 1000000: inter-byte timeout in clocks. Only used when `CMD_TIMEOUT_EN` is defined; must be ≥2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  reset, asynchronous and active-high; all registers clear immediately on assertion.
- `rx_data`  in  8  received byte from the UART receiver; valid while `rx_rdy`=1.
- `rx_rdy`  in  1  level; stays high until cleared by `clr_rx_rdy`.
- `clr_rx_rdy`  out  1  combinational one-cycle acknowledge of `rx_data`.
- `cmd`  out  16  assembled command `{high_byte, low_byte}`.
- `cmd_rdy`  out  1  level; a new command is held on `cmd`.
- `clr_cmd_rdy`  in  1  consumer acknowledge; clears `cmd_rdy`.
- `resp`  in  8  response byte to transmit.
- `send_resp`  in  1  one-cycle request to transmit `resp`.
- `tx_data`  out  8  byte presented to the UART transmitter.
- `trmt`  out  1  one-cycle transmit start.
- `tx_done`  in  1  transmitter finished the byte.
- `resp_busy`  out  1  response in flight.
- `resp_sent`  out  1  one-cycle pulse when the response has left the transmitter.
- `timeout_err`  out  1  one-cycle pulse when a partial command is discarded. Tied 0 without `CMD_TIMEOUT_EN`.

## Operation
- **Receive FSM, states HIGH and LOW. Reset state is HIGH.**
- HIGH, `rx_rdy`=1: latch `rx_data` into the internal high-byte register, assert `clr_rx_rdy`, go to LOW.
- LOW, `rx_rdy`=1: load `cmd` <= `{high_reg, rx_data}`, set `cmd_rdy`, assert `clr_rx_rdy`, go to HIGH.
- `clr_rx_rdy` = `rx_rdy` whenever not in reset. The transceiver drops `rx_rdy` on the following edge, so each byte is consumed exactly once.
- **`cmd` hold rule:** `cmd` changes only on LOW-state completion; it is otherwise stable.
- **`cmd_rdy` set/clear:** set on completion, cleared by `clr_cmd_rdy`. If both occur in the same cycle, set wins.
- **Overrun:** a new command completing while `cmd_rdy`=1 overwrites `cmd` and leaves `cmd_rdy`=1. No error is flagged.
- **Transmit path:**
  - `send_resp` while `resp_busy`=0: `tx_data` <= `resp`, `trmt`=1 for exactly one cycle, `resp_busy` <= 1.
  - `send_resp` while `resp_busy`=1 is ignored.
  - `tx_done` while busy: `resp_sent`=1 for one cycle and `resp_busy` <= 0 together.
  - `tx_data` holds its value until the next accepted request.
- **Independence:** the receive and transmit paths are fully independent and may be active in the same cycle.

## Timing
- **Reset values:** `cmd`=0x0000; `cmd_rdy`, `trmt`, `resp_busy`, `resp_sent`, `timeout_err`=0; `tx_data`=0x00; `clr_rx_rdy`=0 while `RST`=1.
- **Reset mid-operation:** a latched high byte is discarded and an in-flight response is abandoned. `resp_sent` does not fire for it.
- **Receive latency:** `cmd`/`cmd_rdy` are valid in the cycle after the edge that samples the low byte.
- **Transmit latency:**
  - `send_resp` sampled at edge N → `trmt`=1 and `tx_data`=`resp` during cycle N+1.
  - `tx_done` sampled at edge M → `resp_sent`=1 during cycle M+1 and `resp_busy`=0 from cycle M+1.
  - A `send_resp` sampled during the `resp_sent` cycle is accepted.
- **Timeout counter:**
  - Counter width is ceil(log2(`TIMEOUT_CYCLES`)). It is cleared on entry to LOW and increments each LOW cycle without `rx_rdy`.
  - On reaching `TIMEOUT_CYCLES`-1, the FSM returns to HIGH, drops the high byte and pulses `timeout_err`.
  - `rx_rdy` on the expiry cycle takes priority: the byte completes the command.

## Configuration
- `CMD_TIMEOUT_EN` defined: inter-byte timeout compiled in as described above; `timeout_err` is live.
- `CMD_TIMEOUT_EN` undefined: no counter; LOW waits indefinitely for the second byte; `timeout_err` is constant 0.

## Test plan
- Bytes 0x24 then 0x35 → `clr_rx_rdy` pulses twice; `cmd`=0x2435, `cmd_rdy`=1 until `clr_cmd_rdy`, then 0; `cmd` still 0x2435.
- `send_resp` with `resp`=0xA5 → one `trmt` cycle with `tx_data`=0xA5. A `send_resp` with 0x5A while busy gives no second `trmt`. `tx_done` → one `resp_sent`; a new `send_resp` with 0x5A then transmits 0x5A.
- With `CMD_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100: byte 0x11, idle 150 cycles, then 0x22, 0x33 → one `timeout_err` pulse; `cmd`=0x2233. Without the macro, the same stimulus yields `cmd`=0x1122.
- Command 0x1234 left unacknowledged, then 0x5678 → `cmd`=0x5678, `cmd_rdy` stays 1. `clr_cmd_rdy` on the same cycle as completion of 0x9ABC → `cmd`=0x9ABC, `cmd_rdy`=1.
- Byte 0xAB, assert `RST` mid-frame, release, then bytes 0xCD, 0xEF → `cmd`=0xCDEF. Reset during a response → `resp_busy`=0 and no `resp_sent`.
- Receive a frame while a 0xA5 response is in flight → both complete with unaltered timing and values.
